// File: rtl/note_pkg.sv
// -----------------------------------------------------------------------------
// note_pkg
// Shared definitions for the polyphonic note player.
//   - note codes (0 = silent, 1..7 = A..G)
//   - per-channel state enum
//   - frequency table and half-period / counter-width helpers, evaluated at
//     elaboration time from the clock frequency
// -----------------------------------------------------------------------------
package note_pkg;

  localparam logic [2:0] NOTE_SILENT = 3'd0;
  localparam logic [2:0] NOTE_A      = 3'd1;
  localparam logic [2:0] NOTE_B      = 3'd2;
  localparam logic [2:0] NOTE_C      = 3'd3;
  localparam logic [2:0] NOTE_D      = 3'd4;
  localparam logic [2:0] NOTE_E      = 3'd5;
  localparam logic [2:0] NOTE_F      = 3'd6;
  localparam logic [2:0] NOTE_G      = 3'd7;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_PLAY = 1'b1
  } ch_state_e;

  // Octave-0 pitch of each note code in Hz (0 for the silent code).
  function automatic int unsigned noteFreq(logic [2:0] n);
    case (n)
      NOTE_A:  return 880;
      NOTE_B:  return 988;
      NOTE_C:  return 1046;
      NOTE_D:  return 1175;
      NOTE_E:  return 1318;
      NOTE_F:  return 1397;
      NOTE_G:  return 1568;
      default: return 0;
    endcase
  endfunction

  // Octave-0 half-period in clock cycles; the silent code maps to 0 so the
  // division never sees a zero frequency.
  function automatic int unsigned hpCalc(int unsigned clkHz, logic [2:0] n);
    if (n == NOTE_SILENT) return 0;
    return clkHz / (2 * noteFreq(n));
  endfunction

  // A is the lowest pitch, so its half-period sets the counter width.
  function automatic int unsigned cntWidth(int unsigned clkHz);
    return $clog2(hpCalc(clkHz, NOTE_A) + 1);
  endfunction

endpackage

// File: rtl/tone_channel.sv
// -----------------------------------------------------------------------------
// tone_channel
// One square-wave tone generator. A down counter toggles the output once per
// effective half-period (base half-period shifted right by the octave field).
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   note_i[2:0]       note code, 0 = silent
//   octave_i[OCT_W]   upward octave shift
//   wave_o            registered square wave
//   active_o          high while a note is sounding
// -----------------------------------------------------------------------------
module tone_channel
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned OCT_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       note_i,
  input  logic [OCT_W-1:0] octave_i,
  output logic             wave_o,
  output logic             active_o
);

  localparam int unsigned CNT_W = cntWidth(CLK_HZ);

  localparam logic [31:0] HP_TAB [8] = '{
    32'(hpCalc(CLK_HZ, NOTE_SILENT)),
    32'(hpCalc(CLK_HZ, NOTE_A)),
    32'(hpCalc(CLK_HZ, NOTE_B)),
    32'(hpCalc(CLK_HZ, NOTE_C)),
    32'(hpCalc(CLK_HZ, NOTE_D)),
    32'(hpCalc(CLK_HZ, NOTE_E)),
    32'(hpCalc(CLK_HZ, NOTE_F)),
    32'(hpCalc(CLK_HZ, NOTE_G))
  };

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             wave_q, wave_d;
  logic [CNT_W-1:0] effHalfPeriod;

  // Effective half-period for the current inputs. The shift is done at 32
  // bits before truncation; a result of zero is clamped to one so very high
  // octaves still toggle every cycle instead of stalling.
  always_comb begin
    effHalfPeriod = CNT_W'(HP_TAB[note_i] >> octave_i);
    if (effHalfPeriod == '0) begin
      effHalfPeriod = CNT_W'(1);
    end
  end

  // Next-state logic. A new period is only picked up when the counter
  // expires, so a note or octave change never truncates the half-cycle that
  // is already in progress.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    wave_d   = wave_q;
    unique case (state_q)
      CH_IDLE: begin
        if (note_i != NOTE_SILENT) begin
          state_d  = CH_PLAY;
          period_d = effHalfPeriod;
          count_d  = effHalfPeriod - CNT_W'(1);
          wave_d   = 1'b0;
        end
      end
      CH_PLAY: begin
        if (note_i == NOTE_SILENT) begin
          state_d  = CH_IDLE;
          count_d  = '0;
          period_d = '0;
          wave_d   = 1'b0;
        end else if (count_q == '0) begin
          wave_d  = ~wave_q;
          if (effHalfPeriod != period_q) begin
            period_d = effHalfPeriod;
          end
          count_d = effHalfPeriod - CNT_W'(1);
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = CH_IDLE;
      end
    endcase
  end

  // State register with synchronous reset to a silent, zeroed channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CH_IDLE;
      count_q  <= '0;
      period_q <= '0;
      wave_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      wave_q   <= wave_d;
    end
  end

  assign wave_o   = wave_q;
  assign active_o = (state_q == CH_PLAY);

endmodule

// File: rtl/poly_note_player.sv
// -----------------------------------------------------------------------------
// poly_note_player
// NUM_CH independent tone channels, a registered popcount mixer and a
// first-order sigma-delta stage that renders the mix onto one speaker pin.
// Ports:
//   clk, reset               system clock, synchronous active-high reset
//   note[3*NUM_CH]           per-channel note code, channel i at [3i+2:3i]
//   octave[OCT_W*NUM_CH]     per-channel octave shift
//   ch_wave[NUM_CH]          per-channel square waves
//   ch_active[NUM_CH]        per-channel sounding flags
//   mix                      registered count of high ch_wave bits
//   speaker                  registered 1-bit density rendering of mix
// -----------------------------------------------------------------------------
module poly_note_player
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned OCT_W  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3*NUM_CH-1:0]          note,
  input  logic [OCT_W*NUM_CH-1:0]      octave,
  output logic [NUM_CH-1:0]            ch_wave,
  output logic [NUM_CH-1:0]            ch_active,
  output logic [$clog2(NUM_CH+1)-1:0]  mix,
  output logic                         speaker
);

  localparam int unsigned MIX_W = $clog2(NUM_CH + 1);
  localparam int unsigned ACC_W = MIX_W + 1;
  localparam logic [ACC_W-1:0] FULL_SCALE = ACC_W'(NUM_CH);

  logic [MIX_W-1:0] mix_q, mix_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             speaker_q, speaker_d;
  logic [ACC_W-1:0] accSum;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tone_channel #(
      .CLK_HZ (CLK_HZ),
      .OCT_W  (OCT_W)
    ) u_channel (
      .clk      (clk),
      .reset    (reset),
      .note_i   (note[3*i +: 3]),
      .octave_i (octave[OCT_W*i +: OCT_W]),
      .wave_o   (ch_wave[i]),
      .active_o (ch_active[i])
    );
  end

  // Popcount of the channel waves; registered below, so mix lags the waves
  // by one cycle.
  always_comb begin
    mix_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mix_d = mix_d + MIX_W'(ch_wave[i]);
    end
  end

  // Sigma-delta: the accumulator stays below NUM_CH, so one extra bit over
  // the mix width is enough headroom for the sum. It integrates the value
  // being loaded into mix, which keeps speaker aligned with mix: full scale
  // always yields 1 and zero always yields 0.
  always_comb begin
    accSum    = acc_q + ACC_W'(mix_d);
    acc_d     = accSum;
    speaker_d = 1'b0;
    if (accSum >= FULL_SCALE) begin
      acc_d     = accSum - FULL_SCALE;
      speaker_d = 1'b1;
    end
  end

  // Mixer and modulator registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mix_q     <= '0;
      acc_q     <= '0;
      speaker_q <= 1'b0;
    end else begin
      mix_q     <= mix_d;
      acc_q     <= acc_d;
      speaker_q <= speaker_d;
    end
  end

  assign mix     = mix_q;
  assign speaker = speaker_q;

endmodule

// File: tb/tb_poly_note_player.sv
// -----------------------------------------------------------------------------
// tb_poly_note_player
// Directed stimulus against poly_note_player (CLK_HZ=17600, 4 channels).
// A timestamp-based model predicts every output each cycle; literal timing
// expectations pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_poly_note_player;

  localparam int unsigned CLK_HZ = 17600;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned OCT_W  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] note;
  logic [7:0]  octave;
  logic [3:0]  ch_wave;
  logic [3:0]  ch_active;
  logic [2:0]  mix;
  logic        speaker;

  int checks   = 0;
  int failures = 0;
  bit cmpEn    = 1'b0;

  always #5 clk = ~clk;

  poly_note_player #(
    .CLK_HZ (CLK_HZ),
    .NUM_CH (NUM_CH),
    .OCT_W  (OCT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .note      (note),
    .octave    (octave),
    .ch_wave   (ch_wave),
    .ch_active (ch_active),
    .mix       (mix),
    .speaker   (speaker)
  );

  // Reference model: each playing channel records the absolute edge number
  // of its next toggle; the half-period is recomputed from the frequency
  // table whenever a toggle happens.
  int freqTab [8] = '{0, 880, 988, 1046, 1175, 1318, 1397, 1568};

  function automatic int modelHalf(int n, int oct);
    int hp;
    hp = CLK_HZ / (2 * freqTab[n]);
    hp = hp >> oct;
    if (hp == 0) hp = 1;
    return hp;
  endfunction

  int cyc = 0;
  bit mPlay [4];
  bit mWave [4];
  int mNext [4];
  int mMix  = 0;
  int mAcc  = 0;
  bit mSpk  = 1'b0;

  always @(posedge clk) begin : modelProc
    int pop;
    int sum;
    int n;
    int o;
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mPlay[c] = 1'b0;
        mWave[c] = 1'b0;
        mNext[c] = 0;
      end
      mMix = 0;
      mAcc = 0;
      mSpk = 1'b0;
    end else begin
      pop = 0;
      for (int c = 0; c < NUM_CH; c++) pop += int'(mWave[c]);
      sum = mAcc + pop;
      if (sum >= NUM_CH) begin
        mSpk = 1'b1;
        mAcc = sum - NUM_CH;
      end else begin
        mSpk = 1'b0;
        mAcc = sum;
      end
      mMix = pop;
      for (int c = 0; c < NUM_CH; c++) begin
        n = int'(note[3*c +: 3]);
        o = int'(octave[OCT_W*c +: OCT_W]);
        if (n == 0) begin
          mPlay[c] = 1'b0;
          mWave[c] = 1'b0;
        end else if (!mPlay[c]) begin
          mPlay[c] = 1'b1;
          mWave[c] = 1'b0;
          mNext[c] = cyc + modelHalf(n, o);
        end else if (cyc == mNext[c]) begin
          mWave[c] = !mWave[c];
          mNext[c] = cyc + modelHalf(n, o);
        end
      end
    end
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t",
               name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin : compareProc
    logic [3:0] expWave;
    logic [3:0] expActive;
    if (cmpEn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        expWave[c]   = mWave[c];
        expActive[c] = mPlay[c];
      end
      checkOutput("model_ch_wave", 32'(ch_wave), 32'(expWave));
      checkOutput("model_ch_active", 32'(ch_active), 32'(expActive));
      checkOutput("model_mix", 32'(mix), 32'(mMix));
      checkOutput("model_speaker", 32'(speaker), 32'(mSpk));
    end
  end

  task automatic applyStimulus(input logic [11:0] n, input logic [7:0] o);
    note   = n;
    octave = o;
  endtask

  task automatic waitCycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic waitActive(input int ch);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ch_active[ch]) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("wait_active", 32'(found), 32'd1);
  endtask

  task automatic waitMix(input int val);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (int'(mix) == val) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("wait_mix", 32'(found), 32'd1);
  endtask

  // Number of cycles until ch_wave[ch] changes; 999 if it never does.
  task automatic measureToggle(input int ch, output int n);
    logic v;
    v = ch_wave[ch];
    n = 999;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (ch_wave[ch] !== v) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int n;
    reset = 1'b1;
    applyStimulus(12'h000, 8'h00);
    waitCycles(3);
    cmpEn = 1'b1;
    checkOutput("reset_ch_wave", 32'(ch_wave), 32'd0);
    checkOutput("reset_ch_active", 32'(ch_active), 32'd0);
    checkOutput("reset_mix", 32'(mix), 32'd0);
    checkOutput("reset_speaker", 32'(speaker), 32'd0);
    reset = 1'b0;
    waitCycles(2);

    // Channel 0 plays A at octave 0: half-period 10, mix one cycle behind.
    applyStimulus(12'h001, 8'h00);
    waitActive(0);
    measureToggle(0, n);
    checkOutput("A_first_rise", 32'(n), 32'd10);
    checkOutput("A_mix_before", 32'(mix), 32'd0);
    @(negedge clk);
    checkOutput("A_mix_after", 32'(mix), 32'd1);
    measureToggle(0, n);
    checkOutput("A_fall_rest", 32'(n), 32'd9);
    measureToggle(0, n);
    checkOutput("A_second_rise", 32'(n), 32'd10);

    // Silence while the wave is high.
    checkOutput("silence_pre", 32'(ch_wave[0]), 32'd1);
    applyStimulus(12'h000, 8'h00);
    @(negedge clk);
    checkOutput("silence_wave", 32'(ch_wave[0]), 32'd0);
    checkOutput("silence_active", 32'(ch_active[0]), 32'd0);
    waitCycles(2);

    // A shifted up two octaves: half-period 2.
    applyStimulus(12'h001, 8'h02);
    waitActive(0);
    measureToggle(0, n);
    checkOutput("oct2_rise", 32'(n), 32'd2);
    measureToggle(0, n);
    checkOutput("oct2_fall", 32'(n), 32'd2);
    measureToggle(0, n);
    checkOutput("oct2_rise2", 32'(n), 32'd2);
    applyStimulus(12'h000, 8'h00);
    waitCycles(2);

    // A changed to G three cycles into the first half-period.
    applyStimulus(12'h001, 8'h00);
    waitActive(0);
    waitCycles(3);
    applyStimulus(12'h007, 8'h00);
    measureToggle(0, n);
    checkOutput("AG_rise", 32'(n), 32'd7);
    measureToggle(0, n);
    checkOutput("AG_fall", 32'(n), 32'd5);
    measureToggle(0, n);
    checkOutput("AG_rise2", 32'(n), 32'd5);
    applyStimulus(12'h000, 8'h00);
    waitCycles(2);

    // Mixed chord: B/oct1, D/oct0, E/oct3 (clamped to 1), F/oct2.
    applyStimulus({3'd6, 3'd5, 3'd4, 3'd2}, {2'd2, 2'd3, 2'd0, 2'd1});
    waitActive(2);
    measureToggle(2, n);
    checkOutput("clamp_toggle", 32'(n), 32'd1);
    waitCycles(20);
    applyStimulus({3'd6, 3'd5, 3'd4, 3'd2}, {2'd2, 2'd3, 2'd1, 2'd1});
    waitCycles(30);
    applyStimulus(12'h000, 8'h00);
    waitCycles(3);

    // All four channels on A together.
    applyStimulus(12'h249, 8'h00);
    waitMix(4);
    checkOutput("all4_speaker_high", 32'(speaker), 32'd1);
    waitMix(0);
    checkOutput("all4_speaker_low", 32'(speaker), 32'd0);
    applyStimulus(12'h000, 8'h00);
    waitCycles(2);

    // Two channels in phase after a reset that clears the accumulator.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(12'h009, 8'h00);
    waitMix(2);
    checkOutput("duty_0", 32'(speaker), 32'd0);
    @(negedge clk);
    checkOutput("duty_1", 32'(speaker), 32'd1);
    @(negedge clk);
    checkOutput("duty_2", 32'(speaker), 32'd0);
    @(negedge clk);
    checkOutput("duty_3", 32'(speaker), 32'd1);
    waitCycles(15);

    // Reset pulse mid-stream, then playback restarts.
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_ch_wave", 32'(ch_wave), 32'd0);
    checkOutput("midreset_ch_active", 32'(ch_active), 32'd0);
    checkOutput("midreset_mix", 32'(mix), 32'd0);
    checkOutput("midreset_speaker", 32'(speaker), 32'd0);
    reset = 1'b0;
    waitActive(0);
    measureToggle(0, n);
    checkOutput("resume_rise", 32'(n), 32'd10);
    waitCycles(5);

    cmpEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
